// File: rtl/alpha_unblend.sv
// Recovers the foreground B of an alpha blend D = A*B + (2^BW-A)*C using a
// restoring divider that produces one quotient bit per cycle.
//
// state  | meaning
// IDLE   | waiting for a request, in_ready high
// CALC   | form the signed numerator, resolve special cases
// DIV    | one restoring-division step per cycle, BW steps
// DONE   | result presented, held until out_ready
module alpha_unblend #(
  parameter int BW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BW-1:0]   A,
  input  logic [BW-1:0]   C,
  input  logic [2*BW-1:0] D,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BW-1:0]   B,
  output logic [BW-1:0]   rem,
  output logic            zero_alpha,
  output logic            underflow,
  output logic            sat
);

  localparam int CW = (BW > 1) ? $clog2(BW) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DIV, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [BW-1:0]     r_a;
  logic [BW-1:0]     r_c;
  logic [2*BW-1:0]   r_d;
  logic [BW-1:0]     r_prem;
  logic [BW-1:0]     r_shf;
  logic [CW-1:0]     r_cnt;
  logic [BW-1:0]     r_b;
  logic [BW-1:0]     r_rem;
  logic              r_zero;
  logic              r_unf;
  logic              r_sat;

  logic [BW:0]       w_inv;
  logic [2*BW:0]     w_prod;
  logic [2*BW+1:0]   w_num;
  logic              w_zero;
  logic              w_neg;
  logic              w_ovf;
  logic              w_special;
  logic [BW:0]       w_shift;
  logic              w_ge;
  logic [BW-1:0]     w_diff;
  logic [BW-1:0]     w_rem_nxt;
  logic              w_last;

  // Numerator is 2*BW+2 bits wide so both the sign and the carry above D fit.
  assign w_inv  = {1'b1, {BW{1'b0}}} - {1'b0, r_a};
  assign w_prod = (2*BW+1)'(w_inv) * (2*BW+1)'(r_c);
  assign w_num  = {2'b00, r_d} - {1'b0, w_prod};

  assign w_zero    = (r_a == '0);
  assign w_neg     = w_num[2*BW+1];
  assign w_ovf     = (w_num[2*BW:BW] >= {1'b0, r_a});
  assign w_special = w_zero | w_neg | w_ovf;

  // Quotient bits are shifted into the low end of r_shf as numerator bits leave the top.
  assign w_shift   = {r_prem, r_shf[BW-1]};
  assign w_ge      = (w_shift >= {1'b0, r_a});
  assign w_diff    = w_shift[BW-1:0] - r_a;
  assign w_rem_nxt = w_ge ? w_diff : w_shift[BW-1:0];
  assign w_last    = (r_cnt == CW'(BW-1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_nxt = S_CALC;
      S_CALC:  w_state_nxt = w_special ? S_DONE : S_DIV;
      S_DIV:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_c    <= '0;
      r_d    <= '0;
      r_prem <= '0;
      r_shf  <= '0;
      r_cnt  <= '0;
      r_b    <= '0;
      r_rem  <= '0;
      r_zero <= 1'b0;
      r_unf  <= 1'b0;
      r_sat  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a <= A;
            r_c <= C;
            r_d <= D;
          end
        end
        S_CALC: begin
          r_zero <= 1'b0;
          r_unf  <= 1'b0;
          r_sat  <= 1'b0;
          r_b    <= '0;
          r_rem  <= '0;
          if (w_zero) begin
            r_zero <= 1'b1;
          end else if (w_neg) begin
            r_unf <= 1'b1;
          end else if (w_ovf) begin
            r_sat <= 1'b1;
            r_b   <= '1;
          end else begin
            r_prem <= w_num[2*BW-1:BW];
            r_shf  <= w_num[BW-1:0];
            r_cnt  <= '0;
          end
        end
        S_DIV: begin
          r_prem <= w_rem_nxt;
          r_shf  <= {r_shf[BW-2:0], w_ge};
          r_cnt  <= r_cnt + CW'(1);
          if (w_last) begin
            r_b   <= {r_shf[BW-2:0], w_ge};
            r_rem <= w_rem_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign B          = r_b;
  assign rem        = r_rem;
  assign zero_alpha = r_zero;
  assign underflow  = r_unf;
  assign sat        = r_sat;

endmodule

// File: tb/tb_alpha_unblend.sv
// Randomised and directed checks of alpha_unblend against an integer model
// of the un-blend arithmetic, including latency, backpressure and reset.
module tb_alpha_unblend;

  localparam int BW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [BW-1:0]   A;
  logic [BW-1:0]   C;
  logic [2*BW-1:0] D;
  logic            out_valid;
  logic            out_ready;
  logic [BW-1:0]   B;
  logic [BW-1:0]   rem;
  logic            zero_alpha;
  logic            underflow;
  logic            sat;

  int n_checks = 0;
  int n_errors = 0;

  alpha_unblend #(.BW(BW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .C(C), .D(D),
    .out_valid(out_valid), .out_ready(out_ready),
    .B(B), .rem(rem),
    .zero_alpha(zero_alpha), .underflow(underflow), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the blend equation.
  task automatic model(input int a, input int c, input int d,
                       output int b, output int r, output int z,
                       output int u, output int s, output int lat);
    int n;
    n = d - ((1 << BW) - a) * c;
    b = 0; r = 0; z = 0; u = 0; s = 0; lat = 2;
    if (a == 0)                z = 1;
    else if (n < 0)            u = 1;
    else if ((n >> BW) >= a) begin s = 1; b = (1 << BW) - 1; end
    else begin
      b = n / a;
      r = n % a;
      lat = BW + 2;
    end
  endtask

  // Issue one request; bp = cycles to hold out_ready low once out_valid rises,
  // poke = disturb the inputs while the division is in flight.
  task automatic do_op(input int a, input int c, input int d, input int bp, input bit poke);
    int eb, er, ez, eu, es, elat, cnt;
    logic [BW-1:0] hb, hr;
    logic [2:0] hf;
    model(a, c, d, eb, er, ez, eu, es, elat);
    @(negedge clk);
    check_val("in_ready_idle", in_ready, 1);
    in_valid  = 1'b1;
    A = a[BW-1:0]; C = c[BW-1:0]; D = d[2*BW-1:0];
    out_ready = (bp == 0);
    @(negedge clk);
    in_valid = 1'b0;
    A = $urandom; C = $urandom; D = $urandom;
    cnt = 1;
    while (!out_valid && cnt < 40) begin
      if (poke && cnt == 5) begin
        check_val("in_ready_busy", in_ready, 0);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      A = $urandom; C = $urandom; D = $urandom;
      @(negedge clk);
      cnt++;
    end
    in_valid = 1'b0;
    if (!out_valid) begin
      check_val("timeout", 0, 1);
      return;
    end
    check_val("latency", cnt, elat);
    check_val("B", B, eb);
    check_val("rem", rem, er);
    check_val("flags", {zero_alpha, underflow, sat}, {29'd0, ez[0], eu[0], es[0]});
    if (bp > 0) begin
      hb = B; hr = rem; hf = {zero_alpha, underflow, sat};
      for (int k = 0; k < bp; k++) begin
        @(negedge clk);
        check_val("bp_valid", out_valid, 1);
        check_val("bp_ready", in_ready, 0);
        check_val("bp_hold", {hf, hr, hb}, {zero_alpha, underflow, sat, rem, B});
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    check_val("post_ready", in_ready, 1);
    check_val("post_valid", out_valid, 0);
  endtask

  initial begin
    int cnt, a, c, b;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; C = '0; D = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_outs", {zero_alpha, underflow, sat, rem, B}, 0);

    do_op(128, 50, 19200, 0, 0);
    do_op(3, 0, 100, 0, 0);
    do_op(255, 255, 65280, 0, 0);
    do_op(0, 77, 19712, 0, 0);
    do_op(128, 200, 100, 0, 0);
    do_op(1, 0, 300, 0, 0);
    do_op(128, 50, 19200, 5, 0);
    do_op(7, 13, 5000, 0, 0);
    do_op(200, 100, 30000, 0, 1);

    // Reset during the division, then a clean request.
    @(negedge clk);
    in_valid = 1'b1; A = 128; C = 50; D = 19200;
    @(negedge clk);
    in_valid = 1'b0;
    for (cnt = 1; cnt < 5; cnt++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("midrst_in_ready", in_ready, 1);
    check_val("midrst_out_valid", out_valid, 0);
    check_val("midrst_outs", {zero_alpha, underflow, sat, rem, B}, 0);
    do_op(128, 50, 19200, 0, 0);

    for (int i = 0; i < 40; i++) begin
      a = $urandom_range(0, 255);
      c = $urandom_range(0, 255);
      if (i % 2 == 0) begin
        b = $urandom_range(0, 255);
        do_op(a, c, a * b + (256 - a) * c, $urandom_range(0, 3), (i % 5) == 0);
      end else begin
        do_op(a, c, $urandom_range(0, 65535), $urandom_range(0, 3), 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alpha_unblend.md
Name: alpha_unblend

Overview:
- Inverts the graphics alpha blend D = A*B + (2^BW - A)*C: given the blended value D, the alpha A and the background C, it recovers the foreground B = (D - (2^BW - A)*C) / A.
- Uses an iterative restoring divider, one quotient bit per cycle.
- Valid/ready handshakes on input and output.
- Sits in the compositing datapath for de-compositing and verification of blended layers.

Parameters:
- BW, 8, width of A, B, C; D is 2*BW bits.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request
- A  input  BW  alpha
- C  input  BW  background
- D  input  2*BW  blended value
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- B  output  BW  recovered foreground (quotient)
- rem  output  BW  division remainder
- zero_alpha  output  1  A was 0; B forced to 0
- underflow  output  1  numerator negative; B clamped to 0
- sat  output  1  quotient exceeds 2^BW-1; B forced to all ones

Behaviour:
- Reset values (rst high at an edge): state IDLE, in_ready=1, out_valid=0, B=0, rem=0, all flags 0. Reset overrides everything, including mid-division and a pending result, which is discarded.
- FSM states: IDLE, CALC, DIV, DONE.
- in_ready = (state==IDLE). out_valid = (state==DONE).
- IDLE: on in_valid at an edge, capture A, C, D; go to CALC.
- CALC (one cycle): form signed numerator N = D - (2^BW - A)*C, at width 2*BW+2.
  - Checks are in priority order; the first match sets its flag, the outputs shown, and goes to DONE:
    1. A==0: zero_alpha=1, B=0, rem=0.
    2. N<0: underflow=1, B=0, rem=0.
    3. N[2*BW-1:BW] >= A: sat=1, B=2^BW-1, rem=0.
  - Otherwise load the partial remainder with N[2*BW-1:BW], clear the bit counter, go to DIV.
- DIV: each cycle, shift the next numerator bit (MSB first from N[BW-1:0]) into the partial remainder.
  - If the partial remainder >= A: subtract A, quotient bit=1; else quotient bit=0.
  - After exactly BW iterations, B = quotient, rem = final remainder; go to DONE.
- Flags are mutually exclusive; all are 0 on a normal divide.
- Latency, counted from the input-accepting edge:
  - Normal divide: out_valid is first high after BW+2 edges (10 for BW=8).
  - Special case: out_valid is first high after 2 edges.
- DONE: B, rem and flags hold stable while out_valid=1 and out_ready=0. On out_ready at an edge, go to IDLE.
- Back-to-back operation: in_ready is low in DONE, so a new request is accepted at the earliest one cycle after the output handshake. Minimum initiation interval is BW+3 cycles.
- Input ports are ignored outside IDLE; changes to them never affect an operation in flight.
- Arithmetic is unsigned except N. D is taken as given, modulo 2^(2*BW), with no check that it came from a legal blend.

Test Plan:
- Normal divide (BW=8): A=128, C=50, D=19200, out_ready=1 -> B=100, rem=0, no flags; out_valid first high 10 cycles after the accepting edge.
- Remainder: A=3, C=0, D=100 -> B=33, rem=1, no flags. Round-trip: A=255, C=255, D=65280 -> B=255, rem=0, sat=0.
- Special cases, each 2 cycles after accept:
  - A=0, C=77, D=19712 -> zero_alpha=1, B=0.
  - A=128, C=200, D=100 -> underflow=1, B=0.
  - A=1, C=0, D=300 -> sat=1, B=255, rem=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises -> B, rem and flags stable, in_ready=0 throughout. Raise out_ready -> in_ready=1 the next cycle; next request accepted and correct.
- Reset mid-division: assert rst for one cycle during DIV iteration 4 -> next cycle in_ready=1, out_valid=0, outputs 0. A following request (A=128, C=50, D=19200) gives B=100.
- Input isolation: change A, C, D and pulse in_valid during DIV -> the in-flight result is unchanged and no second request is accepted until after the output handshake.
